// File: rtl/dbg_loader_pkg.sv
// Shared definitions for the UART debug loader.
// Command bytes, reply bytes and parser states.
package dbg_loader_pkg;

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_H = 8'h48;
    localparam logic [7:0] CMD_G = 8'h47;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_MEM,
        S_RESP
    } state_t;

endpackage

// File: rtl/uart_dbg_loader_if.sv
// UART byte streams plus the debug memory bus.
// master = loader side, slave = UART engines / memory mux.
interface uart_dbg_loader_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        dbg_mem_op;
    logic [31:0] dbg_adr;
    logic [31:0] dbg_do;
    logic [3:0]  dbg_wren;
    logic [31:0] dbg_di;

    modport master (
        input  rx_data, rx_valid, tx_ready, dbg_di,
        output tx_data, tx_valid,
        output dbg_mem_op, dbg_adr, dbg_do, dbg_wren
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, dbg_di,
        input  tx_data, tx_valid,
        input  dbg_mem_op, dbg_adr, dbg_do, dbg_wren
    );

endinterface

// File: rtl/dbg_byte_collector.sv
// Little-endian 4-byte assembler used for address and data fields.
// o_word already includes the byte arriving this cycle.
module dbg_byte_collector (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        i_clr,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_done
);

    logic [23:0] r_sr;
    logic [1:0]  r_cnt;

    // Shift bytes in from the top so the first byte ends up lowest.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (i_clr) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (i_valid) begin
            r_sr  <= {i_byte, r_sr[23:8]};
            r_cnt <= r_cnt + 2'd1;
        end
    end

    assign o_word = {i_byte, r_sr};
    assign o_done = i_valid && (r_cnt == 2'd3);

endmodule

// File: rtl/uart_dbg_loader.sv
// Host command parser: UART bytes -> debug memory accesses.
// Also owns the CPU reset line for halt/go.
import dbg_loader_pkg::*;

module uart_dbg_loader #(
    parameter int MEM_HOLD    = 4,
    parameter int TIMEOUT     = 100000,
    parameter bit BOOT_HALTED = 1'b0
) (
    input  logic               clk,
    input  logic               n_reset,
    uart_dbg_loader_if.master  bus,
    output logic               cpu_n_reset,
    output logic               busy,
    output logic               overrun
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int HW = $clog2(MEM_HOLD + 1);

    state_t      r_state;
    logic        r_is_wr;
    logic [29:0] r_addr;
    logic [TW-1:0] r_tmo;
    logic [HW-1:0] r_hold;
    logic [23:0] r_resp;
    logic [2:0]  r_left;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;
    logic        r_mem_op;
    logic [31:0] r_adr;
    logic [31:0] r_do;
    logic [3:0]  r_wren;
    logic        r_cpu_n_reset;
    logic        r_overrun;

    logic [31:0] w_word;
    logic        w_done;
    logic        w_col_valid;
    logic        w_col_clr;
    logic        w_drop;

    assign w_col_valid = bus.rx_valid &&
                         (r_state == S_ADDR || r_state == S_DATA);
    assign w_col_clr   = (r_state == S_IDLE);
    assign w_drop      = bus.rx_valid &&
                         (r_state == S_MEM || r_state == S_RESP);

    dbg_byte_collector u_col (
        .clk     (clk),
        .n_reset (n_reset),
        .i_clr   (w_col_clr),
        .i_valid (w_col_valid),
        .i_byte  (bus.rx_data),
        .o_word  (w_word),
        .o_done  (w_done)
    );

    // Command parser, memory access sequencing and reply streaming.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state       <= S_IDLE;
            r_is_wr       <= 1'b0;
            r_addr        <= '0;
            r_tmo         <= '0;
            r_hold        <= '0;
            r_resp        <= '0;
            r_left        <= '0;
            r_tx_data     <= '0;
            r_tx_valid    <= 1'b0;
            r_mem_op      <= 1'b0;
            r_adr         <= '0;
            r_do          <= '0;
            r_wren        <= '0;
            r_cpu_n_reset <= !BOOT_HALTED;
            r_overrun     <= 1'b0;
        end else begin
            r_overrun <= w_drop;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.rx_valid) begin
                        r_is_wr <= (bus.rx_data == CMD_W);
                        r_tmo   <= '0;
                        case (bus.rx_data)
                            CMD_W, CMD_R: begin
                                r_state <= S_ADDR;
                            end
                            CMD_H: begin
                                r_cpu_n_reset <= 1'b0;
                                r_tx_data     <= ACK;
                                r_tx_valid    <= 1'b1;
                                r_left        <= 3'd1;
                                r_state       <= S_RESP;
                            end
                            CMD_G: begin
                                r_cpu_n_reset <= 1'b1;
                                r_tx_data     <= ACK;
                                r_tx_valid    <= 1'b1;
                                r_left        <= 3'd1;
                                r_state       <= S_RESP;
                            end
                            default: begin
                                r_tx_data  <= NAK;
                                r_tx_valid <= 1'b1;
                                r_left     <= 3'd1;
                                r_state    <= S_RESP;
                            end
                        endcase
                    end
                end
                S_ADDR: begin
                    if (bus.rx_valid) begin
                        r_tmo <= '0;
                        if (w_done) begin
                            r_addr <= w_word[31:2];
                            if (r_is_wr) begin
                                r_state <= S_DATA;
                            end else begin
                                r_mem_op <= 1'b1;
                                r_adr    <= {w_word[31:2], 2'b00};
                                r_do     <= '0;
                                r_wren   <= 4'h0;
                                r_hold   <= '0;
                                r_state  <= S_MEM;
                            end
                        end
                    end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bus.rx_valid) begin
                        r_tmo <= '0;
                        if (w_done) begin
                            r_mem_op <= 1'b1;
                            r_adr    <= {r_addr, 2'b00};
                            r_do     <= w_word;
                            r_wren   <= 4'hF;
                            r_hold   <= '0;
                            r_state  <= S_MEM;
                        end
                    end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_MEM: begin
                    if (r_hold == HW'(MEM_HOLD - 1)) begin
                        r_mem_op   <= 1'b0;
                        r_adr      <= '0;
                        r_do       <= '0;
                        r_wren     <= '0;
                        r_tx_valid <= 1'b1;
                        if (r_is_wr) begin
                            r_tx_data <= ACK;
                            r_left    <= 3'd1;
                        end else begin
                            r_tx_data <= bus.dbg_di[7:0];
                            r_resp    <= bus.dbg_di[31:8];
                            r_left    <= 3'd4;
                        end
                        r_state <= S_RESP;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                S_RESP: begin
                    if (r_tx_valid && bus.tx_ready) begin
                        if (r_left == 3'd1) begin
                            r_tx_valid <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_tx_data <= r_resp[7:0];
                            r_resp    <= {8'h00, r_resp[23:8]};
                            r_left    <= r_left - 3'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_data    = r_tx_data;
    assign bus.tx_valid   = r_tx_valid;
    assign bus.dbg_mem_op = r_mem_op;
    assign bus.dbg_adr    = r_adr;
    assign bus.dbg_do     = r_do;
    assign bus.dbg_wren   = r_wren;
    assign cpu_n_reset    = r_cpu_n_reset;
    assign busy           = (r_state != S_IDLE);
    assign overrun        = r_overrun;

endmodule

// File: tb/tb_uart_dbg_loader.sv
// Bench for uart_dbg_loader: random commands vs a
// word-addressed reference memory and reply model.
module tb_uart_dbg_loader;

    localparam int MEM_HOLD = 4;
    localparam int TIMEOUT  = 64;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  wren;
        int          len;
        bit          stable;
    } txn_t;

    logic clk;
    logic n_reset;
    logic cpu_n_reset;
    logic busy;
    logic overrun;

    uart_dbg_loader_if bus ();

    uart_dbg_loader #(
        .MEM_HOLD    (MEM_HOLD),
        .TIMEOUT     (TIMEOUT),
        .BOOT_HALTED (1'b0)
    ) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .bus         (bus),
        .cpu_n_reset (cpu_n_reset),
        .busy        (busy),
        .overrun     (overrun)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] ref_mem [logic [29:0]];
    logic [31:0] bus_mem [logic [29:0]];
    logic        exp_cpu;

    logic [7:0] txq [$];
    txn_t       memq [$];
    int         ovr_cnt;
    int         tx_unstable;
    int         idle_dirty;
    int         rdy_mode;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_init(input logic [29:0] w);
        return {w[15:0] ^ 16'hBEEF, w[29:14]};
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
        return mem_init(a[31:2]);
    endfunction

    function automatic logic [31:0] bus_rd(input logic [31:0] a);
        if (bus_mem.exists(a[31:2])) return bus_mem[a[31:2]];
        return mem_init(a[31:2]);
    endfunction

    // TX ready driver: random back-pressure or forced stall.
    initial begin
        bus.tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) bus.tx_ready = 1'b0;
            else bus.tx_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // Bus-side monitor: memory mux model, tx capture, overrun count.
    initial begin
        txn_t cur;
        bit   m_in;
        bit   t_hold;
        logic [7:0] t_last;
        m_in = 0;
        t_hold = 0;
        t_last = '0;
        cur = '{adr: '0, dat: '0, wren: '0, len: 0, stable: 1'b1};
        bus.dbg_di = '0;
        forever begin
            @(negedge clk);
            bus.dbg_di = bus_rd(bus.dbg_adr);
            if (bus.dbg_mem_op) begin
                if (!m_in) begin
                    m_in = 1;
                    cur.adr = bus.dbg_adr;
                    cur.dat = bus.dbg_do;
                    cur.wren = bus.dbg_wren;
                    cur.len = 1;
                    cur.stable = 1'b1;
                end else begin
                    cur.len++;
                    if (bus.dbg_adr !== cur.adr || bus.dbg_do !== cur.dat ||
                        bus.dbg_wren !== cur.wren)
                        cur.stable = 1'b0;
                end
            end else begin
                if (m_in) begin
                    m_in = 0;
                    memq.push_back(cur);
                    if (cur.wren == 4'hF && cur.len == MEM_HOLD)
                        bus_mem[cur.adr[31:2]] = cur.dat;
                end
                if (bus.dbg_adr !== 32'h0 || bus.dbg_do !== 32'h0 ||
                    bus.dbg_wren !== 4'h0)
                    idle_dirty++;
            end
            if (bus.tx_valid) begin
                if (t_hold && bus.tx_data !== t_last) tx_unstable++;
                if (bus.tx_ready) begin
                    txq.push_back(bus.tx_data);
                    t_hold = 0;
                end else begin
                    t_hold = 1;
                    t_last = bus.tx_data;
                end
            end else begin
                t_hold = 0;
            end
            if (overrun) ovr_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(posedge clk);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = $urandom_range(0, 255);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], $urandom_range(0, 2));
    endtask

    task automatic clear_mon();
        txq.delete();
        memq.delete();
        ovr_cnt = 0;
        tx_unstable = 0;
        idle_dirty = 0;
    endtask

    task automatic wait_mem_op(input string nm);
        int k;
        k = 0;
        while (!bus.dbg_mem_op && k < 50) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k >= 50) begin
            n_err++;
            $display("FAIL %s mem_op wait: got none want 1 within 50 cycles", nm);
        end
    endtask

    // Run one command end-to-end and check reply, bus access and CPU reset.
    task automatic run_cmd(input logic [7:0] cmd, input logic [31:0] adr,
                           input logic [31:0] dat, input string nm);
        logic [7:0]  exp [$];
        logic [31:0] rv;
        bit          mem_exp;
        logic [31:0] e_do;
        logic [3:0]  e_wren;
        int          k;
        exp = {};
        mem_exp = 0;
        e_do = '0;
        e_wren = '0;
        clear_mon();
        send_byte(cmd, $urandom_range(0, 2));
        if (cmd == 8'h57 || cmd == 8'h52) send_word(adr);
        if (cmd == 8'h57) send_word(dat);
        case (cmd)
            8'h57: begin
                ref_mem[adr[31:2]] = dat;
                exp.push_back(8'h06);
                mem_exp = 1;
                e_do = dat;
                e_wren = 4'hF;
            end
            8'h52: begin
                rv = ref_rd(adr);
                for (int i = 0; i < 4; i++) exp.push_back(rv[8*i +: 8]);
                mem_exp = 1;
            end
            8'h48: begin exp_cpu = 1'b0; exp.push_back(8'h06); end
            8'h47: begin exp_cpu = 1'b1; exp.push_back(8'h06); end
            default: exp.push_back(8'h15);
        endcase
        k = 0;
        while ((txq.size() < exp.size() || busy) && k < 400) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k >= 400) begin
            n_err++;
            $display("FAIL %s done wait: busy=%0b got %0d bytes want %0d",
                     nm, busy, txq.size(), exp.size());
        end
        n_cmp++;
        if (txq.size() != exp.size()) begin
            n_err++;
            $display("FAIL %s reply len: got %0d want %0d", nm, txq.size(), exp.size());
        end
        foreach (exp[i]) begin
            if (i < txq.size()) begin
                n_cmp++;
                if (txq[i] !== exp[i]) begin
                    n_err++;
                    $display("FAIL %s reply[%0d]: got %02h want %02h", nm, i, txq[i], exp[i]);
                end
            end
        end
        n_cmp++;
        if (memq.size() != (mem_exp ? 1 : 0)) begin
            n_err++;
            $display("FAIL %s mem count: got %0d want %0d", nm, memq.size(), mem_exp);
        end
        if (mem_exp && memq.size() == 1) begin
            n_cmp++;
            if (memq[0].adr !== {adr[31:2], 2'b00} || memq[0].dat !== e_do ||
                memq[0].wren !== e_wren) begin
                n_err++;
                $display("FAIL %s mem fields: got %08h/%08h/%h want %08h/%08h/%h",
                         nm, memq[0].adr, memq[0].dat, memq[0].wren,
                         {adr[31:2], 2'b00}, e_do, e_wren);
            end
            n_cmp++;
            if (memq[0].len != MEM_HOLD || !memq[0].stable) begin
                n_err++;
                $display("FAIL %s mem hold: got len %0d stable %0b want %0d stable 1",
                         nm, memq[0].len, memq[0].stable, MEM_HOLD);
            end
        end
        n_cmp++;
        if (cpu_n_reset !== exp_cpu || ovr_cnt != 0 || tx_unstable != 0 || idle_dirty != 0) begin
            n_err++;
            $display("FAIL %s side: cpu=%0b ovr=%0d unst=%0d dirty=%0d want cpu=%0b 0 0 0",
                     nm, cpu_n_reset, ovr_cnt, tx_unstable, idle_dirty, exp_cpu);
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if (cpu_n_reset !== 1'b1 || busy !== 1'b0 || overrun !== 1'b0) begin
            n_err++;
            $display("FAIL reset ctl: got cpu=%0b busy=%0b ovr=%0b want 1 0 0",
                     cpu_n_reset, busy, overrun);
        end
        n_cmp++;
        if (bus.dbg_mem_op !== 1'b0 || bus.dbg_adr !== 32'h0 ||
            bus.dbg_do !== 32'h0 || bus.dbg_wren !== 4'h0) begin
            n_err++;
            $display("FAIL reset dbg: got %b %08h %08h %h want all 0",
                     bus.dbg_mem_op, bus.dbg_adr, bus.dbg_do, bus.dbg_wren);
        end
        n_cmp++;
        if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset tx: got %b %02h want 0 00", bus.tx_valid, bus.tx_data);
        end
    endtask

    task automatic test_halt();
        run_cmd(8'h48, 32'h0, 32'h0, "halt");
    endtask

    task automatic test_write();
        run_cmd(8'h57, 32'h0002_0000, 32'h0001_0537, "write");
    endtask

    task automatic test_read_stall();
        logic [7:0] d0;
        logic [7:0] exp [$];
        int k;
        int bad;
        ref_mem[30'h0000_4001] = 32'h0000_0066;
        bus_mem[30'h0000_4001] = 32'h0000_0066;
        exp = {8'h66, 8'h00, 8'h00, 8'h00};
        clear_mon();
        rdy_mode = 1;
        send_byte(8'h52, 0);
        send_word(32'h0001_0007);
        k = 0;
        while (!bus.tx_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        d0 = bus.tx_data;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus.tx_valid || bus.tx_data !== d0) bad++;
        end
        n_cmp++;
        if (k >= 50 || bad != 0 || d0 !== 8'h66) begin
            n_err++;
            $display("FAIL read stall: got first=%02h unstable=%0d wait=%0d want 66 0 <50",
                     d0, bad, k);
        end
        rdy_mode = 0;
        k = 0;
        while ((txq.size() < 4 || busy) && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (txq.size() != 4 || k >= 200) begin
            n_err++;
            $display("FAIL read len: got %0d want 4", txq.size());
        end
        foreach (exp[i]) begin
            if (i < txq.size()) begin
                n_cmp++;
                if (txq[i] !== exp[i]) begin
                    n_err++;
                    $display("FAIL read byte[%0d]: got %02h want %02h", i, txq[i], exp[i]);
                end
            end
        end
        n_cmp++;
        if (memq.size() != 1 || memq[0].adr !== 32'h0001_0004 ||
            memq[0].wren !== 4'h0 || memq[0].len != MEM_HOLD) begin
            n_err++;
            $display("FAIL read access: got n=%0d adr=%08h wren=%h want 1 00010004 0",
                     memq.size(), memq.size() ? memq[0].adr : 32'h0,
                     memq.size() ? memq[0].wren : 4'h0);
        end
        n_cmp++;
        if (tx_unstable != 0) begin
            n_err++;
            $display("FAIL read txdata: got %0d changes while stalled want 0", tx_unstable);
        end
    endtask

    task automatic test_timeout();
        logic b_mid;
        clear_mon();
        send_byte(8'h57, 0);
        for (int i = 0; i < 3; i++) send_byte(8'h10 + 8'(i), 1);
        @(negedge clk);
        b_mid = busy;
        repeat (TIMEOUT + 20) @(negedge clk);
        n_cmp++;
        if (b_mid !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL timeout busy: got mid=%0b after=%0b want 1 0", b_mid, busy);
        end
        n_cmp++;
        if (memq.size() != 0 || txq.size() != 0) begin
            n_err++;
            $display("FAIL timeout quiet: got mem=%0d tx=%0d want 0 0", memq.size(), txq.size());
        end
        run_cmd(8'h47, 32'h0, 32'h0, "go");
    endtask

    task automatic test_nak_overrun();
        int k;
        run_cmd(8'h41, 32'h0, 32'h0, "nak");
        clear_mon();
        ref_mem[30'h0123_4567] = 32'hCAFE_F00D;
        send_byte(8'h57, 0);
        send_word(32'h048D_159C);
        send_word(32'hCAFE_F00D);
        wait_mem_op("ovr");
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hAA;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        k = 0;
        while ((txq.size() < 1 || busy) && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (ovr_cnt != 1) begin
            n_err++;
            $display("FAIL ovr pulse: got %0d cycles want 1", ovr_cnt);
        end
        n_cmp++;
        if (memq.size() != 1 || memq[0].dat !== 32'hCAFE_F00D ||
            memq[0].adr !== 32'h048D_159C || memq[0].len != MEM_HOLD) begin
            n_err++;
            $display("FAIL ovr write: got n=%0d dat=%08h want 1 cafef00d",
                     memq.size(), memq.size() ? memq[0].dat : 32'h0);
        end
        n_cmp++;
        if (txq.size() != 1 || txq[0] !== 8'h06) begin
            n_err++;
            $display("FAIL ovr ack: got n=%0d b=%02h want 1 06",
                     txq.size(), txq.size() ? txq[0] : 8'h00);
        end
        run_cmd(8'h52, 32'h048D_159D, 32'h0, "ovr_rb");
    endtask

    task automatic test_reset_mid();
        run_cmd(8'h48, 32'h0, 32'h0, "halt2");
        clear_mon();
        send_byte(8'h57, 0);
        send_word(32'h0000_0300);
        send_word(32'h1122_3344);
        wait_mem_op("rst");
        @(posedge clk);
        #2;
        n_reset = 1'b0;
        #1;
        exp_cpu = 1'b1;
        n_cmp++;
        if (bus.dbg_mem_op !== 1'b0 || busy !== 1'b0 || cpu_n_reset !== 1'b1 ||
            bus.dbg_wren !== 4'h0) begin
            n_err++;
            $display("FAIL rst mid: got op=%0b busy=%0b cpu=%0b wren=%h want 0 0 1 0",
                     bus.dbg_mem_op, busy, cpu_n_reset, bus.dbg_wren);
        end
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        repeat (2) @(negedge clk);
        run_cmd(8'h52, 32'h0000_0300, 32'h0, "rst_rb");
    endtask

    task automatic test_random();
        logic [31:0] pool [6];
        logic [31:0] a;
        logic [7:0]  c;
        int r;
        foreach (pool[i]) pool[i] = $urandom & 32'hFFFF_FFFC;
        for (int it = 0; it < 24; it++) begin
            r = $urandom_range(0, 9);
            a = pool[$urandom_range(0, 5)] | 32'($urandom_range(0, 3));
            if (r < 4) c = 8'h57;
            else if (r < 7) c = 8'h52;
            else if (r == 7) c = 8'h48;
            else if (r == 8) c = 8'h47;
            else begin
                c = 8'($urandom_range(0, 255));
                while (c == 8'h57 || c == 8'h52 || c == 8'h48 || c == 8'h47)
                    c = 8'($urandom_range(0, 255));
            end
            run_cmd(c, a, $urandom, "rand");
        end
    endtask

    initial begin
        n_reset = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data = '0;
        rdy_mode = 0;
        exp_cpu = 1'b1;
        clear_mon();
        repeat (3) @(negedge clk);
        test_reset();
        n_reset = 1'b1;
        repeat (2) @(negedge clk);
        test_halt();
        test_write();
        test_read_stall();
        test_timeout();
        test_nak_overrun();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
